// File: rtl/sram_req_arbiter_pkg.sv
// Shared types and constants for the IF/MEM sram port arbiter.
package sram_req_arbiter_pkg;

  localparam int unsigned INST_ADDR_BUS = 32;
  localparam int unsigned REG_BUS       = 32;
  localparam int unsigned MEM_SIZE_W    = 2;
  localparam logic        RST_ENABLE    = 1'b0;

  localparam logic [MEM_SIZE_W-1:0] MEM_SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_WAIT_ADDR = 2'd1,
    ARB_WAIT_DATA = 2'd2
  } arb_state_e;

  typedef enum logic {
    ARB_OWNER_INST = 1'b0,
    ARB_OWNER_DATA = 1'b1
  } arb_owner_e;

  // Fields presented to the bridge for one transaction
  typedef struct packed {
    logic                     wr;
    logic [MEM_SIZE_W-1:0]    size;
    logic [INST_ADDR_BUS-1:0] addr;
    logic [REG_BUS-1:0]       wdata;
  } mem_cmd_t;

  function automatic int unsigned streak_width(input int unsigned max_streak);
    return (max_streak < 1) ? 1 : $clog2(max_streak + 1);
  endfunction

endpackage

// File: rtl/sram_req_arbiter_prio_sel.sv
// Combinational winner selection: data first, but fetch is forced in after a bounded data streak.
module arb_prio_sel
  import sram_req_arbiter_pkg::*;
#(
  parameter  int unsigned DATA_STREAK_MAX = 4,
  localparam int unsigned STREAK_W        = streak_width(DATA_STREAK_MAX)
) (
  input  logic                inst_req_i,
  input  logic                data_req_i,
  input  logic [STREAK_W-1:0] streak_i,
  output arb_owner_e          winner_c_o,
  output logic [STREAK_W-1:0] streak_c_o
);

  localparam logic [STREAK_W-1:0] STREAK_CAP = STREAK_W'(DATA_STREAK_MAX);

  logic at_cap;

  assign at_cap = (streak_i == STREAK_CAP);

  // Streak only grows while fetch is actually waiting behind a data grant
  always_comb begin
    winner_c_o = ARB_OWNER_INST;
    streak_c_o = '0;
    if (data_req_i && !(inst_req_i && at_cap)) begin
      winner_c_o = ARB_OWNER_DATA;
      if (inst_req_i) begin
        streak_c_o = at_cap ? STREAK_CAP : streak_i + STREAK_W'(1);
      end
    end
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// Shares one sram-like bridge port between instruction fetch and data access,
// one transaction outstanding, with responses routed back to the owner only.
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
#(
  parameter int unsigned DATA_STREAK_MAX = 4
) (
  input  logic                     cpu_clk_50M,
  input  logic                     cpu_rst_n,
  input  logic                     inst_req,
  input  logic [INST_ADDR_BUS-1:0] inst_addr,
  output logic                     inst_addr_ok,
  output logic                     inst_data_ok,
  output logic [REG_BUS-1:0]       inst_rdata,
  input  logic                     data_req,
  input  logic                     data_wr,
  input  logic [MEM_SIZE_W-1:0]    data_size,
  input  logic [INST_ADDR_BUS-1:0] data_addr,
  input  logic [REG_BUS-1:0]       data_wdata,
  output logic                     data_addr_ok,
  output logic                     data_data_ok,
  output logic [REG_BUS-1:0]       data_rdata,
  output logic                     mem_req,
  output logic                     mem_wr,
  output logic [MEM_SIZE_W-1:0]    mem_size,
  output logic [INST_ADDR_BUS-1:0] mem_addr,
  output logic [REG_BUS-1:0]       mem_wdata,
  input  logic                     mem_addr_ok,
  input  logic                     mem_data_ok,
  input  logic [REG_BUS-1:0]       mem_rdata,
  output logic                     arb_busy
);

  localparam int unsigned STREAK_W = streak_width(DATA_STREAK_MAX);

  arb_state_e          state_q;
  arb_owner_e          owner_q;
  arb_owner_e          winner;
  logic [STREAK_W-1:0] streak_q;
  logic [STREAK_W-1:0] streak_d;
  mem_cmd_t            cmd_q;
  mem_cmd_t            cmd_d;
  logic                mem_req_q;
  logic                addr_hs;
  logic                data_hs;

  arb_prio_sel #(
    .DATA_STREAK_MAX(DATA_STREAK_MAX)
  ) u_prio_sel (
    .inst_req_i(inst_req),
    .data_req_i(data_req),
    .streak_i  (streak_q),
    .winner_c_o(winner),
    .streak_c_o(streak_d)
  );

  // Fields of whichever requester wins this cycle; fetch is always a word read
  always_comb begin
    cmd_d       = '0;
    cmd_d.size  = MEM_SIZE_WORD;
    cmd_d.addr  = inst_addr;
    if (winner == ARB_OWNER_DATA) begin
      cmd_d.wr    = data_wr;
      cmd_d.size  = data_size;
      cmd_d.addr  = data_addr;
      cmd_d.wdata = data_wdata;
    end
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst_n == RST_ENABLE) begin
      state_q   <= ARB_IDLE;
      owner_q   <= ARB_OWNER_INST;
      streak_q  <= '0;
      mem_req_q <= 1'b0;
      cmd_q     <= '0;
    end else begin
      unique case (state_q)
        ARB_IDLE: begin
          if (inst_req || data_req) begin
            owner_q   <= winner;
            streak_q  <= streak_d;
            cmd_q     <= cmd_d;
            mem_req_q <= 1'b1;
            state_q   <= ARB_WAIT_ADDR;
          end
        end
        // A data_ok arriving before the address handshake is ignored
        ARB_WAIT_ADDR: begin
          if (mem_addr_ok) begin
            mem_req_q <= 1'b0;
            state_q   <= ARB_WAIT_DATA;
          end
        end
        ARB_WAIT_DATA: begin
          if (mem_data_ok) begin
            state_q <= ARB_IDLE;
          end
        end
        default: begin
          mem_req_q <= 1'b0;
          state_q   <= ARB_IDLE;
        end
      endcase
    end
  end

  assign addr_hs = (state_q == ARB_WAIT_ADDR) && mem_addr_ok;
  assign data_hs = (state_q == ARB_WAIT_DATA) && mem_data_ok;

  assign inst_addr_ok = addr_hs && (owner_q == ARB_OWNER_INST);
  assign data_addr_ok = addr_hs && (owner_q == ARB_OWNER_DATA);
  assign inst_data_ok = data_hs && (owner_q == ARB_OWNER_INST);
  assign data_data_ok = data_hs && (owner_q == ARB_OWNER_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  assign mem_req   = mem_req_q;
  assign mem_wr    = cmd_q.wr;
  assign mem_size  = cmd_q.size;
  assign mem_addr  = cmd_q.addr;
  assign mem_wdata = cmd_q.wdata;
  assign arb_busy  = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Randomized scoreboard bench for sram_req_arbiter: a transaction-level model predicts
// each grant; a separate monitor checks the bridge command and response routing.
module tb_sram_req_arbiter;

  localparam int STREAK_MAX = 4;

  typedef struct packed {
    logic        owner;  // 1 = data
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok, arb_busy;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  sram_req_arbiter #(.DATA_STREAK_MAX(STREAK_MAX)) dut (
    .cpu_clk_50M (clk),
    .cpu_rst_n   (rst_n),
    .inst_req    (inst_req),
    .inst_addr   (inst_addr),
    .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .inst_rdata  (inst_rdata),
    .data_req    (data_req),
    .data_wr     (data_wr),
    .data_size   (data_size),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .data_rdata  (data_rdata),
    .mem_req     (mem_req),
    .mem_wr      (mem_wr),
    .mem_size    (mem_size),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_addr_ok (mem_addr_ok),
    .mem_data_ok (mem_data_ok),
    .mem_rdata   (mem_rdata),
    .arb_busy    (arb_busy)
  );

  always #5 clk = ~clk;

  // Shared between model (writer) and stimulus/monitor (readers)
  txn_t exp_q[$];
  int   m_phase = 0;
  int   m_streak = 0;
  int   m_igrant = 0, m_iack = 0, m_dgrant = 0, m_dack = 0;
  logic m_owner = 1'b0;

  // Stimulus-side state
  int   i_ack_seen = 0, d_ack_seen = 0;
  logic i_busy = 1'b0, d_busy = 1'b0;
  int   i_rate = 0, d_rate = 0, spur = 0, scr = 0;
  int   a_lo = 0, a_hi = 0, d_lo = 0, d_hi = 0;
  int   bp = 0, bcnt = 0;
  logic end_req = 1'b0;

  // Monitor-side state
  int   n_tests = 0, n_fail = 0;
  logic done = 1'b0;
  logic mon_active = 1'b0;
  int   mph = 0;
  logic rst_seen = 1'b0;
  txn_t cur = '0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: grant decisions from the arbitration rules, seen at the sampling point
  always @(negedge clk) begin : model
    txn_t t;
    logic take_data;
    if (!rst_n) begin
      m_phase  = 0;
      m_streak = 0;
      exp_q.delete();
      m_iack   = m_igrant;
      m_dack   = m_dgrant;
    end else if (m_phase == 0) begin
      if (inst_req || data_req) begin
        take_data = data_req && !(inst_req && m_streak == STREAK_MAX);
        if (take_data) begin
          m_streak = inst_req ? ((m_streak + 1 > STREAK_MAX) ? STREAK_MAX : m_streak + 1) : 0;
          t = '{owner: 1'b1, wr: data_wr, size: data_size, addr: data_addr, wdata: data_wdata};
          m_dgrant++;
        end else begin
          m_streak = 0;
          t = '{owner: 1'b0, wr: 1'b0, size: 2'd2, addr: inst_addr, wdata: 32'd0};
          m_igrant++;
        end
        m_owner = t.owner;
        exp_q.push_back(t);
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (mem_addr_ok) begin
        m_phase = 2;
        if (m_owner) m_dack++;
        else         m_iack++;
      end
    end else if (mem_data_ok) begin
      m_phase = 0;
    end
  end

  // Monitor: pops the expected grant when mem_req appears and checks the whole transaction
  always @(negedge clk) begin : monitor
    logic [5:0] exp_st;
    if (!rst_n) begin
      mon_active = 1'b0;
      rst_seen   = 1'b1;
    end else begin
      if (rst_seen) begin
        chk("reset_state", 128'({mem_req, mem_wr, mem_size, mem_addr, mem_wdata, arb_busy,
                                 inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}), 128'(0));
        rst_seen = 1'b0;
      end
      if (mem_req && !mon_active) begin
        chk("grant_predicted", 128'(exp_q.size() != 0), 128'(1));
        if (exp_q.size() != 0) begin
          cur        = exp_q.pop_front();
          mon_active = 1'b1;
          mph        = 1;
        end
      end
      exp_st = {mon_active && mph == 1,
                mon_active,
                mon_active && mph == 1 && mem_addr_ok && !cur.owner,
                mon_active && mph == 1 && mem_addr_ok &&  cur.owner,
                mon_active && mph == 2 && mem_data_ok && !cur.owner,
                mon_active && mph == 2 && mem_data_ok &&  cur.owner};
      chk("req_busy_oks", 128'({mem_req, arb_busy, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}),
          128'(exp_st));
      if (mon_active && mph == 1) begin
        chk("mem_cmd", 128'({mem_wr, mem_size, mem_addr, mem_wdata}),
            128'({cur.wr, cur.size, cur.addr, cur.wdata}));
        if (mem_addr_ok) mph = 2;
      end else if (mon_active && mph == 2 && mem_data_ok) begin
        chk("rdata", 128'({inst_rdata, data_rdata}), 128'({mem_rdata, mem_rdata}));
        mon_active = 1'b0;
      end
      if (end_req && !done) begin
        chk("drained", 128'({exp_q.size() == 0, mon_active, m_phase == 0}), 128'({1'b1, 1'b0, 1'b1}));
        done = 1'b1;
      end
    end
  end

  // One clock of stimulus: requesters react to model acks, bridge answers mem_req
  task automatic cycle();
    @(posedge clk);
    #1;
    if (i_ack_seen != m_iack) begin
      i_ack_seen = m_iack;
      i_busy     = 1'b0;
      inst_req   = 1'b0;
    end
    if (!i_busy && $urandom_range(99) < i_rate) begin
      i_busy    = 1'b1;
      inst_req  = 1'b1;
      inst_addr = $urandom() & 32'hFFFF_FFFC;
    end
    if (d_ack_seen != m_dack) begin
      d_ack_seen = m_dack;
      d_busy     = 1'b0;
      data_req   = 1'b0;
    end
    if (!d_busy && $urandom_range(99) < d_rate) begin
      d_busy     = 1'b1;
      data_req   = 1'b1;
      data_wr    = 1'($urandom_range(1));
      data_size  = 2'($urandom_range(2));
      data_addr  = $urandom();
      data_wdata = $urandom();
    end else if (d_busy && m_dgrant != m_dack && $urandom_range(99) < scr) begin
      data_req   = 1'b0;
      data_wr    = 1'b0;
      data_size  = 2'd0;
      data_addr  = 32'd0;
      data_wdata = 32'd0;
    end
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = $urandom();
    if (!rst_n) begin
      bp = 0;
    end else begin
      if (bp == 0 && mem_req) begin
        bp   = 1;
        bcnt = $urandom_range(a_hi, a_lo);
      end
      if (bp == 1) begin
        if (bcnt == 0) begin
          mem_addr_ok = 1'b1;
          bp          = 2;
          bcnt        = $urandom_range(d_hi, d_lo);
        end else begin
          bcnt--;
          if ($urandom_range(99) < spur) mem_data_ok = 1'b1;
        end
      end else if (bp == 2) begin
        if (bcnt == 0) begin
          mem_data_ok = 1'b1;
          bp          = 0;
        end else begin
          bcnt--;
        end
      end
    end
  endtask

  task automatic wait_idle(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      cycle();
      if (!i_busy && !d_busy && m_phase == 0 && exp_q.size() == 0) break;
    end
  endtask

  task automatic set_bridge(input int alo, input int ahi, input int dlo, input int dhi);
    a_lo = alo; a_hi = ahi; d_lo = dlo; d_hi = dhi;
  endtask

  initial begin
    inst_req = 1'b0; inst_addr = 32'd0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = 32'd0; data_wdata = 32'd0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'd0;
    rst_n = 1'b0;
    repeat (3) cycle();
    rst_n = 1'b1;

    // Lone fetch at the boot vector
    set_bridge(2, 2, 3, 3);
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000; i_busy = 1'b1;
    wait_idle(50);

    // Fetch and load arrive together: load goes first
    set_bridge(1, 1, 1, 1);
    inst_req = 1'b1; inst_addr = $urandom() & 32'hFFFF_FFFC; i_busy = 1'b1;
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h8000_1000;
    data_wdata = 32'd0; d_busy = 1'b1;
    wait_idle(80);

    // Byte store whose inputs are cleared right after the grant
    set_bridge(3, 3, 1, 1);
    scr = 100;
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0; data_addr = 32'h8000_0003;
    data_wdata = 32'h0000_00A5; d_busy = 1'b1;
    wait_idle(50);
    scr = 0;

    // Premature data_ok from the bridge while the address is pending
    set_bridge(4, 4, 2, 2);
    spur = 100;
    inst_req = 1'b1; inst_addr = 32'h1000_0040; i_busy = 1'b1;
    wait_idle(50);
    spur = 0;

    // Both ports saturated: data streak must yield to fetch
    set_bridge(0, 1, 0, 1);
    i_rate = 100; d_rate = 100;
    repeat (200) cycle();
    i_rate = 0; d_rate = 0;
    wait_idle(100);

    // Reset while waiting for data drops the transaction
    set_bridge(1, 1, 6, 6);
    inst_req = 1'b1; inst_addr = 32'h0000_1000; i_busy = 1'b1;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (m_phase == 2) break;
    end
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    wait_idle(30);

    // Random traffic, light then heavy
    set_bridge(0, 3, 0, 3);
    spur = 10; scr = 30; i_rate = 40; d_rate = 40;
    repeat (3000) cycle();
    i_rate = 75; d_rate = 75;
    repeat (2000) cycle();
    i_rate = 0; d_rate = 0;
    wait_idle(200);

    end_req = 1'b1;
    for (int i = 0; i < 10 && !done; i++) cycle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
